scaler_h_lb: RTL and testbench

Line-buffered, multi-channel horizontal scaler using linear interpolation. Each input line is captured into a ping-pong line buffer, then resampled at `scale_step` (4.12 fixed point) and replayed at one output pixel per clock. Upscale (step < 4096) and downscale (step > 4096) both work regardless of input `de_i` duty cycle. The block sits in the video scaler pipeline ahead of the vertical scaler and uses the same de/hs/vs stream format.

---
 rtl/scaler_h_lb.sv | 130 +++++++++++++
 tb/tb_scaler_h_lb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_h_lb.sv
// scaler_h_lb: line-buffered multi-channel horizontal linear-interpolation scaler.
// Lines are captured into a ping-pong buffer and replayed resampled at one pixel per clock.
module scaler_h_lb #(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNELS      = 3,
    parameter int LINE_SIZE_MAX = 4096,
    parameter int PIXEL_STEP    = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [15:0]                    scale_step,
    input  logic [CHANNELS*DATA_WIDTH-1:0] di_i,
    input  logic                           de_i,
    input  logic                           hs_i,
    input  logic                           vs_i,
    output logic [CHANNELS*DATA_WIDTH-1:0] do_o,
    output logic                           de_o,
    output logic                           hs_o,
    output logic                           vs_o,
    output logic                           ovf_o
);
    localparam int AW  = $clog2(LINE_SIZE_MAX);
    localparam int FB  = $clog2(PIXEL_STEP);
    localparam int ACW = AW + FB + 1;
    localparam int MW  = DATA_WIDTH + FB + 1;
    localparam int PW  = CHANNELS * DATA_WIDTH;
    localparam logic [MW-1:0] ONE  = MW'(PIXEL_STEP);
    localparam logic [MW-1:0] HALF = MW'(PIXEL_STEP / 2);

    typedef enum logic {IDLE, RUN} state_t;

    // Two copies per bank so pixel p and p+1 are fetched in the same cycle.
    logic [PW-1:0]  ram_a [2**(AW+1)];
    logic [PW-1:0]  ram_b [2**(AW+1)];
    state_t         state;
    logic [AW:0]    wr_cnt, len_m1;
    logic           wb, trunc, hs_d, eol, wr_en, v1, v2;
    logic [15:0]    step;
    logic [ACW-1:0] acc, acc_nx, lim;
    logic [AW-1:0]  pa, pb;
    logic [FB-1:0]  f1;
    logic [PW-1:0]  rd_a, rd_b, pix;
    logic [MW-1:0]  ma [CHANNELS];
    logic [MW-1:0]  mb [CHANNELS];

    assign eol    = hs_i & ~hs_d;
    assign wr_en  = de_i & ~hs_i & (wr_cnt != (AW+1)'(LINE_SIZE_MAX));
    assign acc_nx = acc + ACW'(step);
    assign lim    = {len_m1, FB'(0)};
    assign pa     = acc[FB +: AW];
    assign pb     = ({1'b0, pa} == len_m1) ? pa : pa + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_a[{wb, wr_cnt[AW-1:0]}] <= di_i;
            ram_b[{wb, wr_cnt[AW-1:0]}] <= di_i;
        end
        rd_a <= ram_a[{~wb, pa}];
        rd_b <= ram_b[{~wb, pb}];
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            ma[c] <= MW'(rd_a[c*DATA_WIDTH +: DATA_WIDTH]) * (ONE - MW'(f1));
            mb[c] <= MW'(rd_b[c*DATA_WIDTH +: DATA_WIDTH]) * MW'(f1);
        end
    end

    always_comb begin
        pix = '0;
        for (int c = 0; c < CHANNELS; c++)
            pix[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((ma[c] + mb[c] + HALF) >> FB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_cnt <= '0;
            len_m1 <= '0;
            trunc  <= 1'b0;
            wb     <= 1'b0;
            hs_d   <= 1'b1;
            acc    <= '0;
            step   <= 16'(PIXEL_STEP);
            f1     <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            do_o   <= '0;
            de_o   <= 1'b0;
            hs_o   <= 1'b1;
            vs_o   <= 1'b1;
            ovf_o  <= 1'b0;
        end else begin
            hs_d  <= hs_i;
            ovf_o <= 1'b0;
            v1    <= 1'b0;
            if (wr_en)
                wr_cnt <= wr_cnt + 1'b1;
            else if (de_i & ~hs_i)
                trunc <= 1'b1;
            // Terminate on the last issued position so the next line can start right away.
            if (state == RUN) begin
                v1  <= 1'b1;
                f1  <= acc[FB-1:0];
                acc <= acc_nx;
                if (acc_nx > lim)
                    state <= IDLE;
            end
            if (vs_i && state == IDLE && !v1 && !v2)
                vs_o <= 1'b1;
            if (eol && wr_cnt != '0) begin
                wr_cnt <= '0;
                trunc  <= 1'b0;
                ovf_o  <= (state != IDLE) | trunc;
                if (state == IDLE) begin
                    wb     <= ~wb;
                    len_m1 <= wr_cnt - 1'b1;
                    step   <= (scale_step < 16'd256) ? 16'd256 : scale_step;
                    acc    <= '0;
                    state  <= RUN;
                    vs_o   <= 1'b0;
                end
            end
            v2   <= v1;
            do_o <= pix;
            de_o <= v2;
            hs_o <= ~v2;
        end
    end
endmodule

// File: tb/tb_scaler_h_lb.sv
// tb_scaler_h_lb: directed-vector bench with a queue scoreboard and an output monitor.
module tb_scaler_h_lb;
    localparam int DW   = 12;
    localparam int CH   = 3;
    localparam int LMAX = 1024;
    localparam int PW   = DW * CH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   scale_step = 16'd4096;
    logic [PW-1:0] di_i = '0;
    logic          de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b1;
    logic [PW-1:0] do_o;
    logic          de_o, hs_o, vs_o, ovf_o;

    int total = 0, bad = 0, out_cnt = 0, n_ovf = 0, c0 = 0;
    logic [PW-1:0] q[$];
    logic [PW-1:0] lbuf [0:2047];
    logic [PW-1:0] mon_e;

    always #5 clk = ~clk;

    scaler_h_lb #(.DATA_WIDTH(DW), .CHANNELS(CH), .LINE_SIZE_MAX(LMAX), .PIXEL_STEP(4096)) dut (
        .clk(clk), .rst(rst), .scale_step(scale_step), .di_i(di_i), .de_i(de_i), .hs_i(hs_i),
        .vs_i(vs_i), .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .ovf_o(ovf_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ovf_o === 1'b1) n_ovf++;
        if (de_o === 1'b1) begin
            out_cnt++;
            check("de_while_hs", 64'(hs_o), 64'(0));
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_pixel got=%0h want=none", do_o);
            end else begin
                mon_e = q.pop_front();
                check("pixel", 64'(do_o), 64'(mon_e));
            end
        end
    end

    function automatic logic [PW-1:0] pk(input int a, input int b, input int c);
        return {12'(c), 12'(b), 12'(a)};
    endfunction

    task automatic fill(input int n, input int kind, input int off);
        for (int x = 0; x < n; x++)
            if (kind == 0) lbuf[x] = pk(x, 2 * x, 4095 - x);
            else lbuf[x] = pk((x * 73 + off * 29) % 4096, (x * x + off) % 4096, ((x * 5 + off * 131) % 4096) ^ 32'h5a5);
    endtask

    task automatic send_line(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            de_i = 1'b1;
            hs_i = 1'b0;
            di_i = lbuf[i];
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                de_i = 1'b0;
            end
        end
        @(negedge clk);
        de_i = 1'b0;
        hs_i = 1'b0;
    endtask

    task automatic eol();
        @(negedge clk);
        de_i = 1'b0;
        hs_i = 1'b1;
    endtask

    task automatic blank(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 5000 && q.size() > 0; i++) @(negedge clk);
        blank(6);
        check(name, 64'(q.size()), 64'(0));
    endtask

    // Reference resampler written from the position/fraction definition.
    task automatic model(input int len, input int st);
        longint lim, va, vb;
        int s, p, f, b;
        logic [PW-1:0] e;
        lim = longint'(len - 1) * 4096;
        s = (st < 256) ? 256 : st;
        for (longint a = 0; a <= lim; a += s) begin
            p = int'(a / 4096);
            f = int'(a % 4096);
            b = (p + 1 < len) ? p + 1 : len - 1;
            e = '0;
            for (int c = 0; c < CH; c++) begin
                va = longint'(lbuf[p][c*DW +: DW]);
                vb = longint'(lbuf[b][c*DW +: DW]);
                e[c*DW +: DW] = 12'((va * (4096 - f) + vb * f + 2048) / 4096);
            end
            q.push_back(e);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        blank(3);
        check("rst_do", 64'(do_o), 64'(0));
        check("rst_de", 64'(de_o), 64'(0));
        check("rst_hs", 64'(hs_o), 64'(1));
        check("rst_vs", 64'(vs_o), 64'(1));
        check("rst_ovf", 64'(ovf_o), 64'(0));
        rst = 1'b0;
        vs_i = 1'b0;
        blank(2);

        fill(8, 0, 0);
        send_line(8, 0);
        c0 = out_cnt;
        eol();
        for (int x = 0; x < 8; x++) q.push_back(pk(x, 2 * x, 4095 - x));
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("byp_de_timing", 64'(de_o), 64'(k >= 4 && k <= 11));
            if (k == 1) begin
                check("byp_ovf", 64'(ovf_o), 64'(0));
                check("byp_vs_clear", 64'(vs_o), 64'(0));
            end
            if (k == 12) check("byp_hs_end", 64'(hs_o), 64'(1));
        end
        drain("byp_drain");
        check("byp_cnt", 64'(out_cnt - c0), 64'(8));

        scale_step = 16'd6144;
        fill(600, 0, 0);
        send_line(600, 0);
        c0 = out_cnt;
        eol();
        for (int k = 0; k < 400; k++) q.push_back(pk((3 * k + 1) / 2, 3 * k, 4095 - (3 * k) / 2));
        drain("down_drain");
        check("down_cnt", 64'(out_cnt - c0), 64'(400));

        for (int r = 0; r < 2; r++) begin
            scale_step = 16'd2048;
            for (int x = 0; x < 4; x++) lbuf[x] = pk(10 * x, 20 * x, 4095 - 10 * x);
            send_line(4, (r == 1) ? 3 : 0);
            c0 = out_cnt;
            eol();
            for (int k = 0; k < 7; k++) q.push_back(pk(5 * k, 10 * k, 4095 - 5 * k));
            drain("up_drain");
            check("up_cnt", 64'(out_cnt - c0), 64'(7));
            blank(2);
        end

        scale_step = 16'd1024;
        fill(100, 1, 1);
        send_line(100, 0);
        c0 = out_cnt;
        eol();
        model(100, 1024);
        blank(19);
        fill(100, 1, 2);
        send_line(100, 0);
        eol();
        @(negedge clk);
        check("ovr_ovf_pulse", 64'(ovf_o), 64'(1));
        @(negedge clk);
        check("ovr_ovf_single", 64'(ovf_o), 64'(0));
        blank(3);
        fill(100, 1, 3);
        send_line(100, 0);
        drain("ovr_drain1");
        check("ovr_cnt1", 64'(out_cnt - c0), 64'(397));
        c0 = out_cnt;
        eol();
        model(100, 1024);
        @(negedge clk);
        check("ovr_third_ovf", 64'(ovf_o), 64'(0));
        drain("ovr_drain3");
        check("ovr_cnt3", 64'(out_cnt - c0), 64'(397));

        scale_step = 16'd3000;
        fill(50, 0, 0);
        send_line(50, 0);
        c0 = out_cnt;
        eol();
        model(50, 3000);
        drain("mc_drain");
        check("mc_cnt", 64'(out_cnt - c0), 64'(67));

        scale_step = 16'd100;
        fill(4, 0, 0);
        send_line(4, 0);
        c0 = out_cnt;
        eol();
        model(4, 100);
        drain("clamp_drain");
        check("clamp_cnt", 64'(out_cnt - c0), 64'(49));

        scale_step = 16'd4096;
        fill(LMAX + 5, 1, 7);
        send_line(LMAX + 5, 0);
        c0 = out_cnt;
        eol();
        for (int x = 0; x < LMAX; x++) q.push_back(lbuf[x]);
        @(negedge clk);
        check("trunc_ovf", 64'(ovf_o), 64'(1));
        drain("trunc_drain");
        check("trunc_cnt", 64'(out_cnt - c0), 64'(LMAX));

        scale_step = 16'd1024;
        fill(100, 1, 9);
        send_line(100, 0);
        c0 = out_cnt;
        eol();
        model(100, 1024);
        for (int i = 0; i < 1000 && out_cnt < c0 + 50; i++) @(negedge clk);
        #2 rst = 1'b1;
        q.delete();
        @(negedge clk);
        check("mid_rst_de", 64'(de_o), 64'(0));
        check("mid_rst_hs", 64'(hs_o), 64'(1));
        check("mid_rst_vs", 64'(vs_o), 64'(1));
        rst = 1'b0;
        blank(20);

        for (int f = 0; f < 2; f++) begin
            vs_i = 1'b0;
            for (int l = 0; l < 3; l++) begin
                scale_step = 16'd5000;
                fill(600, 1, f * 3 + l + 20);
                send_line(600, 0);
                eol();
                model(600, 5000);
                @(negedge clk);
                check("frm_vs_low", 64'(vs_o), 64'(0));
                blank(4);
            end
            drain("frm_drain");
            vs_i = 1'b1;
            blank(3);
            check("frm_vs_high", 64'(vs_o), 64'(1));
        end

        check("ovf_count", 64'(n_ovf), 64'(2));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
